// File: rtl/fp_add_sub_sched.sv
// Round-robin scheduler that time-shares one fp_add_sub unit among N_REQ requesters,
// driving the unit's start/done/reset handshake and routing each result back to its issuer.
module fp_add_sub_sched #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     sub,
  input  logic [N_REQ*32-1:0]  a1_in,
  input  logic [N_REQ*32-1:0]  a2_in,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [31:0]          u_a1,
  output logic [31:0]          u_a2,
  output logic                 u_start,
  output logic                 u_reset,
  input  logic [31:0]          u_result,
  input  logic                 u_done
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, CLR, GAP} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   gsel;
  logic [CW-1:0]   cnt;
  logic            tmo;
  logic            rst_hold;

  // First requesting index strictly after p, wrapping; the smallest offset wins.
  function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [GW-1:0] p);
    logic [GW-1:0] g;
    int            idx;
    g = p;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (r[idx]) g = GW'(idx);
    end
    return g;
  endfunction

  assign gsel = rr_pick(req, ptr);
  assign tmo  = (TIMEOUT != 0) && (cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= GW'(N_REQ - 1);
      u_a1       <= '0;
      u_a2       <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      cnt        <= '0;
      rst_hold   <= 1'b1;
    end else begin
      state    <= state_n;
      rst_hold <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            ptr  <= gsel;
            u_a1 <= a1_in[int'(gsel)*32 +: 32];
            u_a2 <= a2_in[int'(gsel)*32 +: 32] ^ {sub[gsel], 31'b0};
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (u_done) begin
            rsp_result <= u_result;
            rsp_err    <= 1'b0;
          end else if (tmo) begin
            rsp_result <= QNAN;
            rsp_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ptr holds the active grant from ISSUE through RESP
  always_comb begin
    state_n   = state;
    ack       = '0;
    rsp_valid = '0;
    u_start   = 1'b0;
    u_reset   = rst_hold;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (|req) state_n = ISSUE;
      ISSUE: begin
        ack[ptr] = 1'b1;
        u_start  = 1'b1;
        state_n  = WAIT;
      end
      WAIT:  if (u_done || tmo) state_n = RESP;
      RESP: begin
        rsp_valid[ptr] = 1'b1;
        state_n        = CLR;
      end
      CLR: begin
        u_reset = 1'b1;
        state_n = GAP;
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
